// File: rtl/alu_uart_ctrl_pkg.sv
// rtl/alu_uart_ctrl_pkg.sv - FSM state encoding and ALU opcode constants for alu_uart_ctrl
package alu_uart_ctrl_pkg;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CALC    = 3'd3,
        SEND    = 3'd4
    } state_t;

    // Opcodes shared with the alu instance and the benches
    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRL = 6'h02;
    localparam logic [5:0] OP_SRA = 6'h03;

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// rtl/alu_uart_ctrl_if.sv - UART/ALU side signal bundle for alu_uart_ctrl (o_timeout under ALU_CTRL_TIMEOUT_EN)
interface alu_uart_ctrl_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_valid;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_alu_data_A;
    logic [NB_DATA-1:0] o_alu_data_B;
    logic [NB_DATA-1:0] i_alu_result;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_valid;
    logic               i_tx_ready;
    logic               o_busy;
    logic               o_rx_drop;
`ifdef ALU_CTRL_TIMEOUT_EN
    logic               o_timeout;
`endif

    modport master (
        input  i_rx_data, i_rx_valid, i_alu_result, i_tx_ready,
        output o_alu_op, o_alu_data_A, o_alu_data_B, o_tx_data, o_tx_valid,
`ifdef ALU_CTRL_TIMEOUT_EN
        output o_timeout,
`endif
        output o_busy, o_rx_drop
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_alu_result, i_tx_ready,
        input  o_alu_op, o_alu_data_A, o_alu_data_B, o_tx_data, o_tx_valid,
`ifdef ALU_CTRL_TIMEOUT_EN
        input  o_timeout,
`endif
        input  o_busy, o_rx_drop
    );

endinterface

// File: rtl/alu_uart_ctrl_byte_timeout.sv
// rtl/alu_uart_ctrl_byte_timeout.sv - idle-cycle counter with clear/enable and one-cycle expire strobe
module alu_uart_ctrl_byte_timeout #(
    parameter int CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    // Fires on the CYCLES-th consecutive enabled, uncleared cycle
    assign expire = enable && !clear && (cnt == W'(CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || expire) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_uart_ctrl.sv
// rtl/alu_uart_ctrl.sv - collects A, B, opcode bytes from uart_rx, drives the ALU, returns the result to uart_tx
// Optional inter-byte timeout enabled by ALU_CTRL_TIMEOUT_EN.
module alu_uart_ctrl
    import alu_uart_ctrl_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
`ifdef ALU_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 50000
`endif
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    alu_uart_ctrl_if.master bus
);
    state_t             state;
    logic [NB_DATA-1:0] a_q;
    logic [NB_DATA-1:0] b_q;
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] tx_q;
    logic               tx_valid_q;
    logic               busy_q;
    logic               drop_q;
    logic               expire;

`ifdef ALU_CTRL_TIMEOUT_EN
    logic timeout_q;
    logic waiting;

    assign waiting = (state == WAIT_B) || (state == WAIT_OP);

    alu_uart_ctrl_byte_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (i_clk),
        .rst_n  (i_reset_n),
        .clear  (bus.i_rx_valid || !waiting),
        .enable (waiting),
        .expire (expire)
    );

    assign bus.o_timeout = timeout_q;
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_q       <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            drop_q <= 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                WAIT_A: begin
                    if (bus.i_rx_valid) begin
                        a_q   <= bus.i_rx_data;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.i_rx_valid) begin
                        b_q   <= bus.i_rx_data;
                        state <= WAIT_OP;
                    end else if (expire) begin
                        state <= WAIT_A;
`ifdef ALU_CTRL_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                    end
                end
                WAIT_OP: begin
                    if (bus.i_rx_valid) begin
                        op_q   <= bus.i_rx_data[NB_OP-1:0];
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end else if (expire) begin
                        state <= WAIT_A;
`ifdef ALU_CTRL_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                    end
                end
                CALC: begin
                    drop_q     <= bus.i_rx_valid;
                    tx_q       <= bus.i_alu_result;
                    tx_valid_q <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    // A byte landing on the handshake cycle is still discarded
                    drop_q <= bus.i_rx_valid;
                    if (bus.i_tx_ready) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state      <= WAIT_A;
                    end
                end
                default: state <= WAIT_A;
            endcase
        end
    end

    assign bus.o_alu_data_A = a_q;
    assign bus.o_alu_data_B = b_q;
    assign bus.o_alu_op     = op_q;
    assign bus.o_tx_data    = tx_q;
    assign bus.o_tx_valid   = tx_valid_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_rx_drop    = drop_q;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb/tb_alu_uart_ctrl.sv - scoreboard bench for alu_uart_ctrl (timeout case under ALU_CTRL_TIMEOUT_EN)
module tb_alu_uart_ctrl;
    import alu_uart_ctrl_pkg::*;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
`ifdef ALU_CTRL_TIMEOUT_EN
    localparam int TMO = 16;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_uart_ctrl_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    alu_uart_ctrl #(
        .NB_DATA(NB_DATA),
        .NB_OP  (NB_OP)
`ifdef ALU_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    function automatic logic [7:0] alu_model(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRL:  return a >> b[2:0];
            OP_SRA:  return 8'($signed(a) >>> b[2:0]);
            default: return 8'h00;
        endcase
    endfunction

    // External ALU stand-in
    assign bus.i_alu_result = alu_model(bus.o_alu_op, bus.o_alu_data_A, bus.o_alu_data_B);

    int checks = 0;
    int errors = 0;
    int drop_cnt = 0;
    int valid_cycles = 0;
    int tmo_cnt = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_rx_drop)  drop_cnt++;
            if (bus.o_tx_valid) valid_cycles++;
`ifdef ALU_CTRL_TIMEOUT_EN
            if (bus.o_timeout)  tmo_cnt++;
`endif
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got 0x%0h expected no transfer", bus.o_tx_data);
                end else begin
                    check("tx_data", int'(bus.o_tx_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        tick(1);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        send_byte(b);
        send_byte(op);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_alu_op"}, int'(bus.o_alu_op), 0);
        check({tag, "_A"},      int'(bus.o_alu_data_A), 0);
        check({tag, "_B"},      int'(bus.o_alu_data_B), 0);
        check({tag, "_tx_data"},int'(bus.o_tx_data), 0);
        check({tag, "_tx_valid"}, int'(bus.o_tx_valid), 0);
        check({tag, "_busy"},   int'(bus.o_busy), 0);
        check({tag, "_drop"},   int'(bus.o_rx_drop), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, d0, t0;
        logic [5:0] ops [8];
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SRA};

        bus.i_rx_data  = '0;
        bus.i_rx_valid = 1'b0;
        bus.i_tx_ready = 1'b0;

        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // 1: ADD, ready held high
        bus.i_tx_ready = 1'b1;
        exp_q.push_back(8'h08);
        v0 = valid_cycles;
        send_frame(8'h05, 8'h03, 8'h20);
        check("t1_busy_calc", int'(bus.o_busy), 1);
        tick(4);
        check("t1_valid_cycles", valid_cycles - v0, 1);
        check("t1_busy_idle", int'(bus.o_busy), 0);

        // 2: SUB, ready withheld 10 cycles
        bus.i_tx_ready = 1'b0;
        exp_q.push_back(8'hFB);
        send_frame(8'h0F, 8'h14, 8'h22);
        tick(1);
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_valid", int'(bus.o_tx_valid), 1);
            check("t2_hold_data", int'(bus.o_tx_data), 8'hFB);
            tick(1);
        end
        bus.i_tx_ready = 1'b1;
        tick(1);
        check("t2_valid_fall", int'(bus.o_tx_valid), 0);

        // 3: byte during SEND is dropped, then AND frame
        bus.i_tx_ready = 1'b0;
        exp_q.push_back(8'h03);
        send_frame(8'h01, 8'h02, 8'h20);
        tick(1);
        d0 = drop_cnt;
        send_byte(8'hAA);
        tick(1);
        check("t3_drop_pulse", drop_cnt - d0, 1);
        check("t3_still_valid", int'(bus.o_tx_valid), 1);
        bus.i_tx_ready = 1'b1;
        tick(2);
        exp_q.push_back(8'h0F);
        send_frame(8'hFF, 8'h0F, 8'h24);
        tick(3);

        // byte coincident with handshake: dropped, FSM back to WAIT_A
        bus.i_tx_ready = 1'b0;
        exp_q.push_back(8'h30);
        send_frame(8'h10, 8'h20, 8'h20);
        tick(1);
        d0 = drop_cnt;
        bus.i_tx_ready = 1'b1;
        send_byte(8'h77);
        tick(1);
        check("t3_same_cycle_drop", drop_cnt - d0, 1);
        check("t3_same_cycle_valid", int'(bus.o_tx_valid), 0);
        exp_q.push_back(8'h04);
        send_frame(8'h02, 8'h02, 8'h20);
        check("t3_next_A", int'(bus.o_alu_data_A), 8'h02);
        check("t3_next_B", int'(bus.o_alu_data_B), 8'h02);
        tick(3);

        // 4: upper opcode bits ignored; reset in WAIT_OP
        exp_q.push_back(8'h0E);
        send_frame(8'h0C, 8'h0A, 8'hE5);
        check("t4_op", int'(bus.o_alu_op), 6'h25);
        check("t4_A", int'(bus.o_alu_data_A), 8'h0C);
        check("t4_B", int'(bus.o_alu_data_B), 8'h0A);
        tick(3);
        check("t4_regs_kept", int'(bus.o_alu_op), 6'h25);
        send_byte(8'h11);
        send_byte(8'h22);
        check("t4_partial_A", int'(bus.o_alu_data_A), 8'h11);
        rst_n = 1'b0;
        #1;
        check_zero("t4_reset");
        tick(1);
        rst_n = 1'b1;
        tick(1);
        exp_q.push_back(8'h07);
        send_frame(8'h03, 8'h04, 8'h20);
        tick(3);

`ifdef ALU_CTRL_TIMEOUT_EN
        // 5: A only, then idle until the timeout fires
        t0 = tmo_cnt;
        send_byte(8'h33);
        tick(15);
        check("t5_no_early_timeout", tmo_cnt - t0, 0);
        tick(2);
        check("t5_timeout_pulse", tmo_cnt - t0, 1);
        check("t5_A_kept", int'(bus.o_alu_data_A), 8'h33);
        exp_q.push_back(8'h99);
        send_frame(8'h44, 8'h55, 8'h20);
        check("t5_new_A", int'(bus.o_alu_data_A), 8'h44);
        tick(3);
`else
        t0 = tmo_cnt;
        check("t5_no_timeout", tmo_cnt - t0, 0);
`endif

        // 6: 100 random frames, 1-cycle gaps between bytes
        d0 = drop_cnt;
        for (int n = 0; n < 100; n++) begin
            logic [7:0] a, b;
            logic [5:0] op;
            logic [1:0] hi;
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            op = ops[$urandom_range(0, 7)];
            hi = 2'($urandom_range(0, 3));
            exp_q.push_back(alu_model(op, a, b));
            send_byte(a);
            tick(1);
            send_byte(b);
            tick(1);
            send_byte({hi, op});
            tick(2);
        end
        check("t6_no_drops", drop_cnt - d0, 0);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
        check("queue_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
